// File: rtl/count_milestone_fifo.sv
// Milestone recorder for a free-running counter stream: every STEP-th count is queued
// for a valid/ready consumer; flags sequence breaks, drops and LIMIT. Optional macro: COUNT_MILESTONE_DISPLAY_EN.
module count_milestone_fifo #(
    parameter int WIDTH = 32,
    parameter int STEP  = 10,
    parameter int LIMIT = 100,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] count_in,
    input  logic             count_vld,
    output logic [WIDTH-1:0] event_data,
    output logic             event_vld,
    input  logic             event_rdy,
    output logic             overflow,
    output logic [7:0]       drop_cnt,
    output logic             seq_err,
    output logic             done,
    output logic [1:0]       o_dbg_state
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_next_ms;
    logic [WIDTH-1:0] r_prev;
    logic             r_seq_err;
    logic             r_done;

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_level;
    logic             r_overflow;
    logic [7:0]       r_drop_cnt;

    logic w_active;
    logic w_hit;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;
    logic w_limit;
    logic w_seq_bad;

    assign w_active  = (r_state != S_DONE);
    assign w_hit     = count_vld && w_active && (count_in == r_next_ms);
    assign w_full    = (r_level == (AW+1)'(DEPTH));
    assign w_pop     = (r_level != '0) && event_rdy;
    // A full FIFO still accepts a milestone when the head leaves on the same edge.
    assign w_push    = w_hit && (!w_full || w_pop);
    assign w_drop    = w_hit && w_full && !w_pop;
    assign w_limit   = count_vld && w_active && (count_in >= WIDTH'(LIMIT));
    assign w_seq_bad = count_vld && (r_state == S_RUN) && (count_in != r_prev + WIDTH'(1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_next_ms <= WIDTH'(STEP);
            r_prev    <= '0;
            r_seq_err <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            if (w_limit) begin
                r_state <= S_DONE;
                r_done  <= 1'b1;
            end else if (count_vld && r_state == S_IDLE) begin
                r_state <= S_RUN;
            end
            if (w_seq_bad) begin
                r_seq_err <= 1'b1;
            end
            if (count_vld) begin
                r_prev <= count_in;
            end
            // Advances even when the entry is dropped; a restarted counter hits it again.
            if (w_hit) begin
                r_next_ms <= r_next_ms + WIDTH'(STEP);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_overflow <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= count_in;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            r_level <= r_level + (AW+1)'(w_push) - (AW+1)'(w_pop);
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_cnt != 8'hFF) begin
                    r_drop_cnt <= r_drop_cnt + 8'd1;
                end
            end
        end
    end

    assign event_data  = r_mem[r_rd_ptr];
    assign event_vld   = (r_level != '0);
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;
    assign seq_err     = r_seq_err;
    assign done        = r_done;
    assign o_dbg_state = r_state;

`ifdef COUNT_MILESTONE_DISPLAY_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            if (w_push) begin
                $display("[%0t] milestone %0d", $realtime, count_in);
            end
            if (w_drop) begin
                $display("[%0t] milestone %0d dropped", $realtime, count_in);
            end
            if (w_limit) begin
                $display("[%0t] done at count %0d", $realtime, count_in);
            end
        end
    end
`else
    // Silent build: no display logic.
`endif

endmodule

// File: tb/tb_count_milestone_fifo.sv
// Self-checking bench for count_milestone_fifo: directed scenarios plus a randomized
// run compared against a queue-based reference model.
module tb_count_milestone_fifo;

    localparam int W     = 32;
    localparam int STEP  = 10;
    localparam int LIMIT = 100;
    localparam int DEPTH = 4;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [W-1:0]  count_in;
    logic          count_vld;
    logic [W-1:0]  event_data;
    logic          event_vld;
    logic          event_rdy;
    logic          overflow;
    logic [7:0]    drop_cnt;
    logic          seq_err;
    logic          done;
    logic [1:0]    dbg_state;

    count_milestone_fifo #(.WIDTH(W), .STEP(STEP), .LIMIT(LIMIT), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .count_in   (count_in),
        .count_vld  (count_vld),
        .event_data (event_data),
        .event_vld  (event_vld),
        .event_rdy  (event_rdy),
        .overflow   (overflow),
        .drop_cnt   (drop_cnt),
        .seq_err    (seq_err),
        .done       (done),
        .o_dbg_state(dbg_state)
    );

    int passed = 0;
    int total  = 0;

    // ---------------- reference model ----------------
    logic [W-1:0] exp_q[$];
    logic [W-1:0] seen[$];
    logic [W-1:0] m_next;
    logic [W-1:0] m_prev;
    bit           m_run;
    bit           m_done;
    bit           m_over;
    bit           m_seq;
    int           m_drops;

    task automatic m_reset();
        exp_q.delete();
        m_next  = W'(STEP);
        m_prev  = '0;
        m_run   = 0;
        m_done  = 0;
        m_over  = 0;
        m_seq   = 0;
        m_drops = 0;
    endtask

    task automatic m_step(input logic v, input logic [W-1:0] c, input logic r);
        bit pop;
        bit push;
        pop  = (exp_q.size() != 0) && r;
        push = v && !m_done && (c == m_next);
        if (v && m_run && !m_done && (c != m_prev + 32'd1)) m_seq = 1;
        if (pop) void'(exp_q.pop_front());
        if (push) begin
            if (exp_q.size() < DEPTH) exp_q.push_back(c);
            else begin
                m_over = 1;
                if (m_drops < 255) m_drops++;
            end
            m_next = m_next + W'(STEP);
        end
        if (v) begin
            m_prev = c;
            m_run  = 1;
            if (!m_done && c >= W'(LIMIT)) m_done = 1;
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic drive(input logic v, input logic [W-1:0] c, input logic r);
        count_vld = v;
        count_in  = c;
        event_rdy = r;
        @(posedge clk);
        m_step(v, c, r);
        #1;
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            if (event_vld) seen.push_back(event_data);
            drive(1'b0, '0, 1'b1);
        end
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        reset = 1'b0; count_vld = 1'b0; count_in = '0; event_rdy = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        total++; if (event_vld !== 1'b0) $display("FAIL reset_event_vld got %0b want 0", event_vld); else passed++;
        total++; if (event_data !== '0) $display("FAIL reset_event_data got %0h want 0", event_data); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL reset_overflow got %0b want 0", overflow); else passed++;
        total++; if (drop_cnt !== 8'd0) $display("FAIL reset_drop_cnt got %0d want 0", drop_cnt); else passed++;
        total++; if (seq_err !== 1'b0) $display("FAIL reset_seq_err got %0b want 0", seq_err); else passed++;
        total++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else passed++;
        total++; if (dbg_state !== 2'd0) $display("FAIL reset_state got %0d want 0", dbg_state); else passed++;
        reset = 1'b1;
    endtask

    task automatic test_basic();
        test_reset();
        seen.delete();
        for (int c = 0; c <= 25; c++) begin
            drive(1'b1, W'(c), 1'b1);
            total++;
            if (event_vld !== (exp_q.size() != 0))
                $display("FAIL basic_vld c=%0d got %0b want %0b", c, event_vld, exp_q.size() != 0);
            else passed++;
            if (event_vld) seen.push_back(event_data);
        end
        total++; if (seen.size() != 2) $display("FAIL basic_count got %0d want 2", seen.size()); else passed++;
        for (int i = 0; i < seen.size(); i++) begin
            total++; if (seen[i] !== W'(10 * (i + 1))) $display("FAIL basic_data[%0d] got %0d want %0d", i, seen[i], 10 * (i + 1)); else passed++;
        end
        total++; if (seq_err !== 1'b0) $display("FAIL basic_seq_err got %0b want 0", seq_err); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL basic_overflow got %0b want 0", overflow); else passed++;
    endtask

    task automatic test_overflow();
        test_reset();
        for (int c = 0; c <= 69; c++) drive(1'b1, W'(c), 1'b0);
        total++; if (overflow !== 1'b1) $display("FAIL ovf_flag got %0b want 1", overflow); else passed++;
        total++; if (drop_cnt !== 8'd2) $display("FAIL ovf_drop_cnt got %0d want 2", drop_cnt); else passed++;
        total++; if (event_data !== W'(10)) $display("FAIL ovf_head got %0d want 10", event_data); else passed++;
        seen.delete();
        drain(6);
        total++; if (seen.size() != 4) $display("FAIL ovf_count got %0d want 4", seen.size()); else passed++;
        for (int i = 0; i < seen.size(); i++) begin
            total++; if (seen[i] !== W'(10 * (i + 1))) $display("FAIL ovf_data[%0d] got %0d want %0d", i, seen[i], 10 * (i + 1)); else passed++;
        end
        total++; if (event_vld !== 1'b0) $display("FAIL ovf_empty got %0b want 0", event_vld); else passed++;
    endtask

    task automatic test_full_pop();
        test_reset();
        for (int c = 0; c <= 49; c++) drive(1'b1, W'(c), 1'b0);
        drive(1'b1, W'(50), 1'b1);
        total++; if (drop_cnt !== 8'd0) $display("FAIL fullpop_drop_cnt got %0d want 0", drop_cnt); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL fullpop_overflow got %0b want 0", overflow); else passed++;
        total++; if (event_data !== W'(20)) $display("FAIL fullpop_head got %0d want 20", event_data); else passed++;
        seen.delete();
        drain(6);
        total++; if (seen.size() != 4) $display("FAIL fullpop_count got %0d want 4", seen.size()); else passed++;
        for (int i = 0; i < seen.size(); i++) begin
            total++; if (seen[i] !== W'(10 * (i + 2))) $display("FAIL fullpop_data[%0d] got %0d want %0d", i, seen[i], 10 * (i + 2)); else passed++;
        end
    endtask

    task automatic test_seq_err();
        test_reset();
        for (int c = 0; c <= 5; c++) drive(1'b1, W'(c), 1'b0);
        total++; if (seq_err !== 1'b0) $display("FAIL seq_before got %0b want 0", seq_err); else passed++;
        drive(1'b1, W'(3), 1'b0);
        total++; if (seq_err !== 1'b1) $display("FAIL seq_after got %0b want 1", seq_err); else passed++;
        for (int c = 4; c <= 12; c++) drive(1'b1, W'(c), 1'b0);
        seen.delete();
        drain(4);
        total++; if (seen.size() != 1) $display("FAIL seq_push_count got %0d want 1", seen.size()); else passed++;
        for (int i = 0; i < seen.size(); i++) begin
            total++; if (seen[i] !== W'(10)) $display("FAIL seq_push_data got %0d want 10", seen[i]); else passed++;
        end
        total++; if (seq_err !== 1'b1) $display("FAIL seq_sticky got %0b want 1", seq_err); else passed++;
    endtask

    task automatic test_done();
        test_reset();
        seen.delete();
        for (int c = 0; c <= 110; c++) begin
            if (event_vld) seen.push_back(event_data);
            drive(1'b1, W'(c), 1'b1);
            if (c == 99) begin
                total++; if (done !== 1'b0) $display("FAIL done_early got %0b want 0", done); else passed++;
            end
            if (c == 100) begin
                total++; if (done !== 1'b1) $display("FAIL done_at_limit got %0b want 1", done); else passed++;
            end
        end
        drain(2);
        total++; if (seen.size() != 10) $display("FAIL done_count got %0d want 10", seen.size()); else passed++;
        for (int i = 0; i < seen.size(); i++) begin
            total++; if (seen[i] !== W'(10 * (i + 1))) $display("FAIL done_data[%0d] got %0d want %0d", i, seen[i], 10 * (i + 1)); else passed++;
        end
        total++; if (done !== 1'b1) $display("FAIL done_sticky got %0b want 1", done); else passed++;
        total++; if (dbg_state !== 2'd2) $display("FAIL done_state got %0d want 2", dbg_state); else passed++;
        total++; if (event_vld !== 1'b0) $display("FAIL done_no_push got %0b want 0", event_vld); else passed++;
    endtask

    task automatic test_async_reset();
        test_reset();
        for (int c = 0; c <= 20; c++) drive(1'b1, W'(c), 1'b0);
        drive(1'b1, W'(100), 1'b0);
        total++; if (done !== 1'b1) $display("FAIL areset_pre_done got %0b want 1", done); else passed++;
        total++; if (event_vld !== 1'b1) $display("FAIL areset_pre_vld got %0b want 1", event_vld); else passed++;
        reset = 1'b0;
        #1;
        total++; if (event_vld !== 1'b0) $display("FAIL areset_vld got %0b want 0", event_vld); else passed++;
        total++; if (done !== 1'b0) $display("FAIL areset_done got %0b want 0", done); else passed++;
        total++; if (overflow !== 1'b0) $display("FAIL areset_overflow got %0b want 0", overflow); else passed++;
        total++; if (drop_cnt !== 8'd0) $display("FAIL areset_drop_cnt got %0d want 0", drop_cnt); else passed++;
        total++; if (seq_err !== 1'b0) $display("FAIL areset_seq_err got %0b want 0", seq_err); else passed++;
        m_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        seen.delete();
        for (int c = 0; c <= 10; c++) begin
            if (event_vld) seen.push_back(event_data);
            drive(1'b1, W'(c), 1'b1);
        end
        drain(2);
        total++; if (seen.size() != 1) $display("FAIL areset_after_count got %0d want 1", seen.size()); else passed++;
        for (int i = 0; i < seen.size(); i++) begin
            total++; if (seen[i] !== W'(10)) $display("FAIL areset_after_data got %0d want 10", seen[i]); else passed++;
        end
    endtask

    task automatic test_random();
        int c;
        logic v;
        logic r;
        test_reset();
        c = 0;
        for (int i = 0; i < 400; i++) begin
            if (i % 150 == 149) begin
                test_reset();
                c = 0;
            end
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 24) == 0) c = $urandom_range(0, 40);
            drive(v, W'(c), r);
            if (v) c++;
            total++;
            if (event_vld !== (exp_q.size() != 0)) $display("FAIL rnd_vld i=%0d got %0b want %0b", i, event_vld, exp_q.size() != 0);
            else passed++;
            if (exp_q.size() != 0) begin
                total++; if (event_data !== exp_q[0]) $display("FAIL rnd_data i=%0d got %0d want %0d", i, event_data, exp_q[0]); else passed++;
            end
            total++; if (overflow !== m_over) $display("FAIL rnd_overflow i=%0d got %0b want %0b", i, overflow, m_over); else passed++;
            total++; if (drop_cnt !== 8'(m_drops)) $display("FAIL rnd_drop_cnt i=%0d got %0d want %0d", i, drop_cnt, m_drops); else passed++;
            total++; if (seq_err !== m_seq) $display("FAIL rnd_seq_err i=%0d got %0b want %0b", i, seq_err, m_seq); else passed++;
            total++; if (done !== m_done) $display("FAIL rnd_done i=%0d got %0b want %0b", i, done, m_done); else passed++;
        end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_basic();
        test_overflow();
        test_full_pop();
        test_seq_err();
        test_done();
        test_async_reset();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/count_milestone_fifo.md
# count_milestone_fifo

Downstream consumer of the free-running cycle counters (`count_byte`/`count_c` style, 32-bit, +1 per clock). Watches the sampled count stream, records every STEP-th value into a small FIFO drained over a valid/ready port, flags sequence breaks and FIFO overflow, and raises a sticky `done` once the count reaches LIMIT. It gives the simulation top one place to log milestones and decide when to `$finish`.

## Interface
- `WIDTH`, 32: count width.
- `STEP`, 10: milestone spacing; must be ≥1.
- `LIMIT`, 100: count at or above which `done` asserts.
- `DEPTH`, 4: FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  sole clock, all state on posedge.
- `reset`  in  1  asynchronous, active-low; all state cleared while low.
- `count_in`  in  WIDTH  sampled counter value.
- `count_vld`  in  1  `count_in` valid this cycle.
- `event_data`  out  WIDTH  head-of-FIFO milestone value.
- `event_vld`  out  1  FIFO non-empty.
- `event_rdy`  in  1  consumer accepts head when high with `event_vld`.
- `overflow`  out  1  sticky: a milestone was dropped.
- `drop_cnt`  out  8  dropped milestones, saturating at 255.
- `seq_err`  out  1  sticky: non-incrementing sample seen.
- `done`  out  1  sticky: LIMIT reached.

## Operation
- FSM states IDLE, RUN, DONE. Reset → IDLE.
  - IDLE→RUN on first `count_vld`.
  - IDLE or RUN → DONE on any `count_vld` with `count_in >= LIMIT` (unsigned).
  - DONE exits only via reset.
- Registers: `next_ms` (WIDTH, reset = STEP), `prev` (WIDTH, reset 0).
- Milestone: `count_vld && count_in == next_ms` in IDLE/RUN.
  - Push `count_in` into the FIFO.
  - Update `next_ms <= next_ms + STEP`, mod 2^WIDTH.
  - The sample that enters DONE is still checked and pushed.
  - No pushes in DONE.
- Sequence check: in RUN, a `count_vld` with `count_in != prev + 1` (mod 2^WIDTH) sets `seq_err`.
  - `next_ms` is not adjusted, so a counter restarting at 0 hits the pending milestone again.
  - 0xFFFFFFFF→0 is a valid increment.
- `prev` loads `count_in` on every `count_vld`.
- FIFO:
  - Pop when `event_vld && event_rdy`.
  - A push is accepted when not full, or when full with a same-cycle pop.
  - A push while full without a pop is dropped: `overflow` ← 1, `drop_cnt` += 1, saturating.
  - Order is strictly FIFO.
  - Pop in DONE continues normally.
- Reset values: `event_vld` = 0, `event_data` = 0, `overflow` = 0, `drop_cnt` = 0, `seq_err` = 0, `done` = 0, FIFO empty.
- Reset low mid-operation discards FIFO contents and clears outputs immediately (asynchronous).

## Timing
- Sample on edge N → entry pushed at edge N; `event_vld` high after edge N if the FIFO was empty.
  - Latency is one cycle, measured from `count_vld` being high before edge N.
- `event_data` is registered head, valid whenever `event_vld` = 1; stable until popped.
- Pop at edge N → next head, or `event_vld` = 0, after edge N.
- Throughput: one push and one pop per cycle.
- `done`, `seq_err`, `overflow` and `drop_cnt` update at the edge that samples the causing input.
- Reset release: first sampling edge is the first posedge with `reset` high.

## Configuration
- `COUNT_MILESTONE_DISPLAY_EN`
  - Defined: `$display("[%0t] milestone %0d", $realtime, count_in)` on each accepted push; `$display` on each drop and on entry to DONE.
  - Undefined: no display statements compiled; RTL behaviour identical.

## Test plan
All scenarios use STEP=10, LIMIT=100, DEPTH=4.
- Reset low 2 cycles, then counts 0..25 with `event_rdy` = 1 → events 10 and 20, each `event_vld` for one cycle starting the cycle after the sample; `seq_err` = 0, `overflow` = 0.
- `event_rdy` = 0, counts 0..69 → FIFO holds 10, 20, 30, 40; 50 and 60 dropped, `overflow` = 1, `drop_cnt` = 2. Then `event_rdy` = 1 → 10, 20, 30, 40 in order, then `event_vld` = 0.
- FIFO full (10..40), `event_rdy` = 1 on the cycle sample 50 arrives → 10 popped and 50 accepted; `drop_cnt` unchanged.
- Counts 0..5, then 3, 4, ..., 12 → `seq_err` = 1 after the sample of 3; milestone 10 pushed exactly once.
- Counts 0..110 → pushes 10..100 (10 events); `done` = 1 after the sample of 100; no push at 110; `done` stays 1.
- Reset driven low while FIFO holds 2 entries and `done` = 1 → `event_vld`, `done`, `overflow` and `drop_cnt` go to 0 without a clock edge. After release, counts 0..10 → single event 10.
